reorder_pingpong: RTL and testbench
===================================

Name: reorder_pingpong

Overview:
- Second-generation bit-reversal reorder unit for the multipoint FFT output path.
- Two ping-pong banks: one frame is written in bit-reversed order while the previous frame is read out in natural order, giving continuous 1-sample/cycle streaming.
- Adds over the previous generation:
  - valid/ready handshakes on both sides;
  - per-frame size and bypass latching;
  - out_last framing;
  - parametrised maximum size.

Parameters:
- DATA_WIDTH, 16: width of each of the real and imaginary parts.
- LOG2_MAX_N, 11: log2 of the maximum FFT size. Bank depth is 2^LOG2_MAX_N. Legal range is 3..11.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_re  in  DATA_WIDTH  input real part, bit-reversed order.
- in_im  in  DATA_WIDTH  input imaginary part.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- np  in  4  size select; N = 2^(np+3) (0→8 … 8→2048).
- bypass  in  1  1 = write linearly (no reorder) for this frame.
- out_re  out  DATA_WIDTH  output real part, natural order.
- out_im  out  DATA_WIDTH  output imaginary part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts a sample.
- out_last  out  1  marks sample N-1 of the frame.

Behaviour:
- Size decode:
  - log2N = np+3.
  - If np+3 > LOG2_MAX_N, or np > 8, use N=8 (log2N=3).
- Frame latching:
  - np and bypass are sampled on the first accepted sample of a frame (wcnt==0).
  - The first write uses the live decode. Later samples use the latched values.
  - Changes to np or bypass mid-frame have no effect until the next frame.
- Banks:
  - Two banks, A and B, each of depth 2^LOG2_MAX_N for re and for im.
  - Each bank has a state: FREE, FILLING or FULL.
  - Each bank also records the latched log2N for its frame.
- Write side:
  - wbank (reset A) and wcnt (reset 0).
  - in_ready = rst_n && (state[wbank] != FULL).
  - A sample is accepted when in_valid && in_ready. It is written to address bitrev(wcnt, log2N), where addr[i] = wcnt[log2N-1-i] and the upper bits are 0. In bypass the address is wcnt.
  - The first accept marks the bank FILLING.
  - On the accept with wcnt==N-1: the bank becomes FULL, wcnt returns to 0, and wbank toggles.
- Read side:
  - rbank (reset A), rcnt (reset 0), active = (state[rbank]==FULL).
  - load = active && (!out_valid || out_ready).
  - On load:
    - out_re/out_im <= mem[rbank][rcnt] (synchronous read straight into the output register);
    - out_valid <= 1;
    - out_last <= (rcnt==N-1);
    - rcnt increments.
  - When rcnt==N-1 loads: the bank becomes FREE at that edge, rcnt returns to 0, and rbank toggles.
  - If out_ready && !load, then out_valid <= 0 and out_last <= 0.
  - While out_valid && !out_ready, out_re, out_im and out_last hold stable.
- Latency:
  - The last input is accepted at edge k. The first output is valid after edge k+1, provided out_ready was high or out_valid was 0.
  - With in_valid=out_ready=1 continuously, both streams run with no bubbles after the first frame. in_ready never drops.
- Hazards:
  - The writer can never target a FULL bank, so a bank is never written while it is being read.
  - A bank freed at edge t is writable from cycle t+1 (in_ready is combinational on state).
- Simultaneous events: write completion on one bank and read completion on the other in the same cycle are handled independently. Both state updates apply.
- Full condition: when both banks are FULL, in_ready=0.
- Empty condition: when both banks are FREE or FILLING, out_valid falls once the held sample is accepted.
- Reset (synchronous, mid-operation allowed):
  - All banks become FREE; wbank=rbank=A; wcnt=rcnt=0.
  - out_valid=0, out_last=0, out_re=out_im=0.
  - Partial frames are discarded.
  - Memory contents are not reset.

Test Plan:
- Single 8-point frame: np=0, in=0..7, out_ready=1 -> out = 0,4,2,6,1,5,3,7 (input index order); out_last on the 8th sample; first out_valid 2 edges after the 8th accept.
- Back-to-back: four 16-point frames (np=1), continuous valid, out_ready=1 -> in_ready stays 1, outputs are 64 contiguous cycles with no bubbles, and each frame is correctly reordered.
- Backpressure:
  - Two 32-point frames with out_ready toggled pseudo-randomly -> data held stable while stalled; no loss or duplication.
  - With out_ready=0 throughout, in_ready falls after 64 accepts.
- Bypass and np change: frame 1 uses np=3 with bypass=1; np switches to 2 at sample 10. Frame 2 uses np=2 with bypass=0. -> Frame 1 outputs 64 samples in input order; frame 2 outputs 32 samples bit-reversed.
- Invalid np and reset: np=15 -> 8-point behaviour. Asserting rst_n=0 for 1 cycle mid-frame (sample 5 of 2048) -> out_valid=0 next cycle, in_ready=1 after release, and the next frame reorders correctly.

Source files
------------

// File: rtl/reorder_pingpong.sv
// Bit-reversal reorder for the FFT output path: two ping-pong banks, one filled in bit-reversed order while the other drains in natural order.
// Latency: the first output is registered one edge after the frame's last input is accepted; streaming is 1 sample/cycle.
// Backpressure: in_ready drops while the write bank is still FULL; the output register holds while out_valid && !out_ready.
module reorder_pingpong #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_MAX_N = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            np,
    input  logic                  bypass,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);
    localparam int AW    = LOG2_MAX_N;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    bank_state_t             bank_state [2];
    logic [3:0]              bank_log2n [2];
    logic                    wbank;
    logic                    rbank;
    logic [AW-1:0]           wcnt;
    logic [AW-1:0]           rcnt;
    logic [3:0]              lat_log2n;
    logic                    lat_bypass;
    logic [2*DATA_WIDTH-1:0] mem [2*DEPTH];

    logic [4:0]              np_plus3;
    logic [3:0]              live_log2n;
    logic [3:0]              cur_log2n;
    logic                    cur_bypass;
    logic [AW-1:0]           wmask;
    logic [AW-1:0]           rmask;
    logic [AW-1:0]           wrev;
    logic [AW-1:0]           waddr;
    logic                    wr_en;
    logic                    wr_last;
    logic                    rd_active;
    logic                    load;
    logic                    rd_last;

    // N-1 as a mask of log2N ones
    function automatic logic [AW-1:0] size_mask(input logic [3:0] l2n);
        logic [AW-1:0] m;
        m = '0;
        for (int i = 0; i < AW; i++) begin
            m[i] = (i < int'(l2n));
        end
        return m;
    endfunction

    // Out-of-range sizes fall back to the 8-point frame
    always_comb begin
        np_plus3 = {1'b0, np} + 5'd3;
        if (np > 4'd8 || np_plus3 > 5'(LOG2_MAX_N)) begin
            live_log2n = 4'd3;
        end else begin
            live_log2n = np_plus3[3:0];
        end
    end

    // The first sample of a frame uses the live controls; the rest use the latched copy
    assign cur_log2n  = (wcnt == '0) ? live_log2n : lat_log2n;
    assign cur_bypass = (wcnt == '0) ? bypass : lat_bypass;
    assign wmask      = size_mask(cur_log2n);
    assign rmask      = size_mask(bank_log2n[rbank]);

    // Full-width reversal, then shifted down so only the low log2N bits remain
    always_comb begin
        wrev = '0;
        for (int i = 0; i < AW; i++) begin
            wrev[i] = wcnt[AW-1-i];
        end
    end
    assign waddr = cur_bypass ? wcnt : (wrev >> (4'(AW) - cur_log2n));

    assign in_ready  = rst_n && (bank_state[wbank] != BANK_FULL);
    assign wr_en     = in_valid && in_ready;
    assign wr_last   = (wcnt == wmask);
    assign rd_active = (bank_state[rbank] == BANK_FULL);
    assign load      = rd_active && (!out_valid || out_ready);
    assign rd_last   = (rcnt == rmask);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wbank, waddr}] <= {in_re, in_im};
        end
    end

    // Writer and reader never own the same bank, so both bank updates can land together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_state[0] <= BANK_FREE;
            bank_state[1] <= BANK_FREE;
            bank_log2n[0] <= 4'd3;
            bank_log2n[1] <= 4'd3;
            wbank         <= 1'b0;
            rbank         <= 1'b0;
            wcnt          <= '0;
            rcnt          <= '0;
            lat_log2n     <= 4'd3;
            lat_bypass    <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_re        <= '0;
            out_im        <= '0;
        end else begin
            if (wr_en) begin
                if (wcnt == '0) begin
                    lat_log2n         <= live_log2n;
                    lat_bypass        <= bypass;
                    bank_log2n[wbank] <= live_log2n;
                    bank_state[wbank] <= BANK_FILLING;
                end
                if (wr_last) begin
                    bank_state[wbank] <= BANK_FULL;
                    wcnt              <= '0;
                    wbank             <= ~wbank;
                end else begin
                    wcnt <= wcnt + AW'(1);
                end
            end

            if (load) begin
                {out_re, out_im} <= mem[{rbank, rcnt}];
                out_valid        <= 1'b1;
                out_last         <= rd_last;
                if (rd_last) begin
                    bank_state[rbank] <= BANK_FREE;
                    rcnt              <= '0;
                    rbank             <= ~rbank;
                end else begin
                    rcnt <= rcnt + AW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reorder_pingpong.sv
// Self-checking bench for reorder_pingpong: random data against a frame-level reorder model.
module tb_reorder_pingpong;
    localparam int DW   = 16;
    localparam int LMAX = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_re, in_im, out_re, out_im;
    logic          in_valid, in_ready, bypass, out_valid, out_ready, out_last;
    logic [3:0]    np;

    reorder_pingpong #(.DATA_WIDTH(DW), .LOG2_MAX_N(LMAX)) dut (
        .clk(clk), .rst_n(rst_n), .in_re(in_re), .in_im(in_im), .in_valid(in_valid),
        .in_ready(in_ready), .np(np), .bypass(bypass), .out_re(out_re), .out_im(out_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } smp_t;

    smp_t exp_q[$];
    smp_t obs_q[$];
    smp_t frame_buf[$];
    int   obs_cyc[$];
    int   cyc, last_acc_cyc, inrdy_low, stall_viol, stall_cnt;
    int   m_log2n;
    bit   m_bypass, rand_rdy, prev_stall;
    smp_t prev_out;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ord8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic int brev(int x, int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = (r << 1) | ((x >> b) & 1);
        return r;
    endfunction

    // Reference: collect a whole frame, then emit it in natural order
    function automatic void model_accept(logic [DW-1:0] re, logic [DW-1:0] im, logic [3:0] np_v, logic byp_v);
        int n;
        if (frame_buf.size() == 0) begin
            m_log2n  = (int'(np_v) > 8 || int'(np_v) + 3 > LMAX) ? 3 : int'(np_v) + 3;
            m_bypass = byp_v;
        end
        frame_buf.push_back('{re: re, im: im, last: 1'b0});
        n = 1 << m_log2n;
        if (frame_buf.size() == n) begin
            for (int j = 0; j < n; j++) begin
                int   src;
                smp_t s;
                src    = m_bypass ? j : brev(j, m_log2n);
                s      = frame_buf[src];
                s.last = (j == n - 1);
                exp_q.push_back(s);
            end
            frame_buf.delete();
        end
    endfunction

    // One clock: observe handshakes just before the edge, then step to the next negedge
    task automatic tick(output bit acc_in);
        bit   acc_out;
        smp_t cur;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        #1;
        cur = '{re: out_re, im: out_im, last: out_last};
        if (prev_stall) begin
            stall_cnt++;
            if (!out_valid || cur != prev_out) stall_viol++;
        end
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        if (in_valid && !in_ready) inrdy_low++;
        if (acc_out) begin
            obs_q.push_back(cur);
            obs_cyc.push_back(cyc);
        end
        if (acc_in) begin
            model_accept(in_re, in_im, np, bypass);
            last_acc_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = cur;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(int re);
        bit acc = 1'b0;
        int budget = 2000;
        in_valid = 1'b1;
        in_re    = DW'(re);
        in_im    = DW'($urandom);
        while (!acc && budget > 0) begin
            tick(acc);
            budget--;
        end
        if (!acc) begin
            n_checks++;
            $display("FAIL send_timeout got no accept want accept of %0d", re);
        end
    endtask

    task automatic drain(int budget);
        bit a;
        in_valid = 1'b0;
        while (obs_q.size() < exp_q.size() && budget > 0) begin
            tick(a);
            budget--;
        end
        repeat (4) tick(a);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        bit a;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; np = 4'd0; bypass = 1'b0;
        in_re = '0; in_im = '0; rand_rdy = 1'b0; prev_stall = 1'b0; cyc = 0;
        @(negedge clk);
        tick(a);
        tick(a);
        n_checks++;
        if ({out_valid, out_last, out_re, out_im} !== '0)
            $display("FAIL reset_outputs got %b/%b/%h/%h want all zero", out_valid, out_last, out_re, out_im);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got %b want 0", in_ready);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_release got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        np = 4'd0; bypass = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(i);
        drain(100);
        n_checks++;
        if (obs_cyc.size() == 0 || obs_cyc[0] - last_acc_cyc != 2)
            $display("FAIL single_latency got %0d want 2", obs_cyc.size() ? obs_cyc[0] - last_acc_cyc : -1);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 8) $display("FAIL single_count got %0d want 8", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].re !== DW'(ord8[i]) || obs_q[i].last !== (i == 7))
                $display("FAIL single_order[%0d] got %0d/%b want %0d/%b", i, obs_q[i].re, obs_q[i].last, ord8[i], i == 7);
            else n_pass++;
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size()) $display("FAIL single_data[%0d] got missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL single_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        np = 4'd1; bypass = 1'b0; out_ready = 1'b1; inrdy_low = 0;
        for (int i = 0; i < 64; i++) send(i);
        drain(300);
        n_checks++;
        if (inrdy_low !== 0) $display("FAIL b2b_in_ready got %0d stalled cycles want 0", inrdy_low);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 64) $display("FAIL b2b_count got %0d want 64", obs_q.size());
        else n_pass++;
        n_checks++;
        if (obs_cyc.size() != 64 || obs_cyc[63] - obs_cyc[0] != 63)
            $display("FAIL b2b_bubbles got span %0d want 63", obs_cyc.size() ? obs_cyc[obs_cyc.size()-1] - obs_cyc[0] : -1);
        else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size()) $display("FAIL b2b_data[%0d] got missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_queues();
    endtask

    task automatic test_backpressure();
        bit a;
        int acc_cnt = 0;
        np = 4'd2; bypass = 1'b0; rand_rdy = 1'b1; stall_viol = 0; stall_cnt = 0;
        for (int i = 0; i < 64; i++) send(i);
        drain(2000);
        rand_rdy = 1'b0;
        n_checks++;
        if (stall_viol !== 0 || stall_cnt == 0)
            $display("FAIL bp_hold got %0d violations in %0d stalls want 0 in >0", stall_viol, stall_cnt);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== 64) $display("FAIL bp_count got %0d want 64", obs_q.size());
        else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size()) $display("FAIL bp_data[%0d] got missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL bp_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_queues();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_re = DW'($urandom);
            in_im = DW'($urandom);
            tick(a);
            if (a) acc_cnt++;
        end
        #1;
        n_checks++;
        if (acc_cnt !== 64) $display("FAIL bp_fill_accepts got %0d want 64", acc_cnt);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got %b want 0", in_ready);
        else n_pass++;
        out_ready = 1'b1;
        drain(400);
        n_checks++;
        if (obs_q.size() !== 64) $display("FAIL bp_full_count got %0d want 64", obs_q.size());
        else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size()) $display("FAIL bp_full_data[%0d] got missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL bp_full_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_queues();
    endtask

    task automatic test_bypass_np();
        np = 4'd3; bypass = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 96; i++) begin
            if (i == 10) begin
                np = 4'd2;
                bypass = 1'b0;
            end
            send(i);
        end
        drain(400);
        n_checks++;
        if (obs_q.size() !== 96) $display("FAIL byp_count got %0d want 96", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 64 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].re !== DW'(i) || obs_q[i].last !== (i == 63))
                $display("FAIL byp_linear[%0d] got %0d/%b want %0d/%b", i, obs_q[i].re, obs_q[i].last, i, i == 63);
            else n_pass++;
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size()) $display("FAIL byp_data[%0d] got missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL byp_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_queues();
    endtask

    task automatic test_invalid_np_reset();
        bit a;
        np = 4'd15; bypass = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(i);
        drain(100);
        n_checks++;
        if (obs_q.size() !== 8) $display("FAIL np15_count got %0d want 8", obs_q.size());
        else n_pass++;
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].re !== DW'(ord8[i]) || obs_q[i].last !== (i == 7))
                $display("FAIL np15_order[%0d] got %0d/%b want %0d/%b", i, obs_q[i].re, obs_q[i].last, ord8[i], i == 7);
            else n_pass++;
        end
        clear_queues();

        out_ready = 1'b0; np = 4'd0;
        for (int i = 0; i < 8; i++) send(i);
        in_valid = 1'b0;
        repeat (3) tick(a);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rst_pre_valid got %b want 1", out_valid);
        else n_pass++;
        np = 4'd8;
        for (int i = 0; i < 5; i++) send(i);
        rst_n = 1'b0;
        in_valid = 1'b1;
        tick(a);
        n_checks++;
        if ({out_valid, out_last, out_re, out_im} !== '0)
            $display("FAIL rst_mid_outputs got %b/%b/%h/%h want all zero", out_valid, out_last, out_re, out_im);
        else n_pass++;
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", in_ready);
        else n_pass++;
        clear_queues();
        frame_buf.delete();
        prev_stall = 1'b0;

        out_ready = 1'b1; np = 4'd1;
        for (int i = 0; i < 16; i++) send(i);
        drain(200);
        n_checks++;
        if (obs_q.size() !== 16) $display("FAIL rst_after_count got %0d want 16", obs_q.size());
        else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= obs_q.size()) $display("FAIL rst_after_data[%0d] got missing want %h", i, exp_q[i]);
            else if (obs_q[i] !== exp_q[i]) $display("FAIL rst_after_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        clear_queues();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_bypass_np();
        test_invalid_np_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
